sha256_nonce_scheduler: RTL and testbench

Sequences the shared sha256 core through a nonce search for one block header.
- Per nonce: builds the message, issues one hash (two with the optional feature), compares the digest against a target.
- Stops on the first hit, at the end of the range, or on abort.
- Sits between the host/config logic and the sha256 datapath.
- Sole driver of the core's message, length and start inputs.

---
 rtl/sha256_nonce_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_sha256_nonce_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_scheduler.sv
// Nonce-search sequencer driving a shared sha256 core for one block header.
// Define SHA256_DOUBLE_HASH_EN to hash each message twice, bitcoin style.
module sha256_nonce_scheduler #(
    parameter int HEADER_W = 608,
    parameter int NONCE_W  = 32,
    parameter int MSG_W    = 1024,
    parameter int LEN_W    = 10,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [HEADER_W-1:0] header,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [255:0]        target,
    output logic [MSG_W-1:0]    core_msg,
    output logic [LEN_W-1:0]    core_len,
    output logic                core_start,
    input  logic                core_done,
    input  logic [255:0]        core_digest,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [255:0]        found_digest,
    output logic [CNT_W-1:0]    hash_count
);

    localparam int BODY_W = HEADER_W + NONCE_W;
    localparam int PAD1_W = MSG_W - BODY_W;
    localparam logic [LEN_W-1:0] LEN1 = LEN_W'(BODY_W);
`ifdef SHA256_DOUBLE_HASH_EN
    localparam int PAD2_W = MSG_W - 256;
    localparam logic [LEN_W-1:0] LEN2 = LEN_W'(256);
`endif

    // S_SKIP gives an empty range the same start->done spacing as a search
    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FIN
`ifdef SHA256_DOUBLE_HASH_EN
        ,
        S_ISSUE2,
        S_WAIT2
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [HEADER_W-1:0] r_header;
    logic [NONCE_W-1:0]  r_nonce;
    logic [NONCE_W-1:0]  r_nonce_end;
    logic [255:0]        r_target;
    logic [255:0]        r_digest;
    logic                r_found;
    logic [NONCE_W-1:0]  r_found_nonce;
    logic [255:0]        r_found_digest;
    logic [CNT_W-1:0]    r_count;

    logic                w_hit;
    logic                w_last;
    logic                w_core_start;
    logic                w_busy;
    logic                w_done;
    logic [MSG_W-1:0]    w_msg;
    logic [LEN_W-1:0]    w_len;

    assign w_hit  = (r_digest <= r_target);
    assign w_last = (r_nonce == r_nonce_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_core_start = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_msg        = '0;
        w_len        = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (nonce_start > nonce_end) ? S_SKIP : S_ISSUE;
                end
            end
            S_SKIP: begin
                w_busy = 1'b1;
                w_next = S_FIN;
            end
            S_ISSUE: begin
                w_busy       = 1'b1;
                w_core_start = 1'b1;
                w_msg        = {r_header, r_nonce, {PAD1_W{1'b0}}};
                w_len        = LEN1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                w_msg  = {r_header, r_nonce, {PAD1_W{1'b0}}};
                w_len  = LEN1;
                if (core_done) begin
`ifdef SHA256_DOUBLE_HASH_EN
                    w_next = S_ISSUE2;
`else
                    w_next = S_CHECK;
`endif
                end
            end
`ifdef SHA256_DOUBLE_HASH_EN
            S_ISSUE2: begin
                w_busy       = 1'b1;
                w_core_start = 1'b1;
                w_msg        = {r_digest, {PAD2_W{1'b0}}};
                w_len        = LEN2;
                w_next       = S_WAIT2;
            end
            S_WAIT2: begin
                w_busy = 1'b1;
                w_msg  = {r_digest, {PAD2_W{1'b0}}};
                w_len  = LEN2;
                if (core_done) begin
                    w_next = S_CHECK;
                end
            end
`endif
            S_CHECK: begin
                w_busy = 1'b1;
                if (w_hit || w_last || abort) begin
                    w_next = S_FIN;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_header       <= '0;
            r_nonce        <= '0;
            r_nonce_end    <= '0;
            r_target       <= '0;
            r_digest       <= '0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_found_digest <= '0;
            r_count        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_header       <= header;
                        r_nonce        <= nonce_start;
                        r_nonce_end    <= nonce_end;
                        r_target       <= target;
                        r_found        <= 1'b0;
                        r_found_nonce  <= '0;
                        r_found_digest <= '0;
                        r_count        <= '0;
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_digest <= core_digest;
                    end
                end
`ifdef SHA256_DOUBLE_HASH_EN
                S_WAIT2: begin
                    if (core_done) begin
                        r_digest <= core_digest;
                    end
                end
`endif
                S_CHECK: begin
                    if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    // a hit wins over both abort and range end
                    if (w_hit) begin
                        r_found        <= 1'b1;
                        r_found_nonce  <= r_nonce;
                        r_found_digest <= r_digest;
                    end else if (!w_last && !abort) begin
                        r_nonce <= r_nonce + NONCE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_msg     = w_msg;
    assign core_len     = w_len;
    assign core_start   = w_core_start;
    assign busy         = w_busy;
    assign done         = w_done;
    assign found        = r_found;
    assign found_nonce  = r_found_nonce;
    assign found_digest = r_found_digest;
    assign hash_count   = r_count;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: delayed core model plus a
// search-level reference model over directed and random ranges.
module tb_sha256_nonce_scheduler;

    localparam int HW  = 608;
    localparam int NW  = 32;
    localparam int MW  = 1024;
    localparam int LW  = 10;
    localparam int CW  = 32;
    localparam int LAT = 20;
`ifdef SHA256_DOUBLE_HASH_EN
    localparam int HASHES = 2;
`else
    localparam int HASHES = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [HW-1:0] header = '0;
    logic [NW-1:0] nonce_start = '0;
    logic [NW-1:0] nonce_end = '0;
    logic [255:0]  target = '0;
    logic [MW-1:0] core_msg;
    logic [LW-1:0] core_len;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [255:0]  core_digest = '0;
    logic          busy;
    logic          done;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic [255:0]  found_digest;
    logic [CW-1:0] hash_count;

    sha256_nonce_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .header(header), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .target(target),
        .core_msg(core_msg), .core_len(core_len),
        .core_start(core_start), .core_done(core_done),
        .core_digest(core_digest), .busy(busy), .done(done),
        .found(found), .found_nonce(found_nonce),
        .found_digest(found_digest), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // core model state
    int            n_start = 0;
    int            left = 0;
    bit            pend = 0;
    int            bad_hold = 0;
    int            bad_overlap = 0;
    int            first_start_cyc = 0;
    int            cdone_cyc = 0;
    logic [MW-1:0] cap_msg = '0;
    logic [LW-1:0] cap_len = '0;
    logic [NW-1:0] issued[$];
    logic [LW-1:0] lens[$];

    // expected results
    bit            e_found;
    logic [NW-1:0] e_nonce;
    logic [255:0]  e_digest;
    int            e_count;
    logic [NW-1:0] e_issued[$];
    int            scyc = 0;
    int            done_cyc = 0;

    function automatic logic [31:0] mix32(logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x >> 16);
        x = x * 32'h7feb352d;
        x = x ^ (x >> 15);
        x = x * 32'h846ca68b;
        x = x ^ (x >> 16);
        return x;
    endfunction

    function automatic logic [255:0] digest_of(logic [MW-1:0] m,
                                               logic [LW-1:0] len);
        logic [31:0]  x;
        logic [255:0] d;
        d = '0;
        case (mode)
            0: d = 256'd1;
            1: d = {224'h0, ~m[415:384]};
            default: begin
                x = 32'(len);
                for (int i = 0; i < 32; i++) x = mix32(x ^ m[i*32 +: 32]);
                for (int i = 0; i < 8; i++) begin
                    x = mix32(x + 32'(i));
                    d[i*32 +: 32] = x;
                end
                d[0] = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [255:0] ref_digest(logic [HW-1:0] hdr,
                                                logic [NW-1:0] n);
        logic [255:0] d;
        d = digest_of({hdr, n, 384'h0}, 10'd640);
`ifdef SHA256_DOUBLE_HASH_EN
        d = digest_of({d, 768'h0}, 10'd256);
`endif
        return d;
    endfunction

    // Search in plain arithmetic: walk the range, stop on hit/end/abort.
    task automatic ref_search(logic [HW-1:0] hdr, logic [NW-1:0] ns,
                              logic [NW-1:0] ne, logic [255:0] tgt,
                              int abort_k);
        logic [255:0] d;
        e_found = 0;
        e_nonce = '0;
        e_digest = '0;
        e_count = 0;
        e_issued.delete();
        for (longint n = longint'(ns); n <= longint'(ne); n++) begin
            d = ref_digest(hdr, n[31:0]);
            e_issued.push_back(n[31:0]);
            e_count++;
            if (d <= tgt) begin
                e_found = 1;
                e_nonce = n[31:0];
                e_digest = d;
                break;
            end
            if (abort_k != 0 && e_count >= abort_k) break;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
            left = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (pend) begin
                if (core_msg !== cap_msg || core_len !== cap_len) bad_hold++;
                left--;
                if (left == 0) begin
                    pend = 0;
                    core_done = 1'b1;
                    core_digest = digest_of(cap_msg, cap_len);
                    cdone_cyc = cyc;
                end
            end
            if (core_start === 1'b1) begin
                if (pend) bad_overlap++;
                pend = 1;
                left = LAT;
                cap_msg = core_msg;
                cap_len = core_len;
                n_start++;
                if (n_start == 1) first_start_cyc = cyc;
                lens.push_back(core_len);
                if (core_len == 10'd640) issued.push_back(core_msg[415:384]);
            end
        end
    end

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] rand_hdr();
        logic [HW-1:0] h;
        for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    task automatic launch(string tag, logic [HW-1:0] hdr, logic [NW-1:0] ns,
                          logic [NW-1:0] ne, logic [255:0] tgt);
        @(negedge clk); #1;
        n_start = 0;
        bad_hold = 0;
        bad_overlap = 0;
        issued.delete();
        lens.delete();
        header = hdr;
        nonce_start = ns;
        nonce_end = ne;
        target = tgt;
        start = 1'b1;
        scyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy"}, 256'(busy), 256'd1);
    endtask

    task automatic wait_starts(string tag, int k, int bound);
        int i;
        i = 0;
        while (n_start < k && i < bound) begin
            @(negedge clk); #1;
            i++;
        end
        chk({tag, ".starts"}, 256'(n_start >= k), 256'd1);
    endtask

    task automatic wait_done(string tag, int bound);
        int  i;
        bit  got;
        i = 0;
        got = 0;
        while (!got && i < bound) begin
            @(negedge clk); #1;
            i++;
            if (done === 1'b1) begin
                got = 1;
                done_cyc = cyc;
            end
        end
        chk({tag, ".done"}, 256'(got), 256'd1);
        @(negedge clk); #1;
        chk({tag, ".pulse"}, 256'(done), 256'd0);
    endtask

    task automatic verify(string tag, bit empty);
        int bad;
        chk({tag, ".found"}, 256'(found), 256'(e_found));
        chk({tag, ".nonce"}, 256'(found_nonce), 256'(e_nonce));
        chk({tag, ".digest"}, found_digest, e_digest);
        chk({tag, ".count"}, 256'(hash_count), 256'(e_count));
        chk({tag, ".nissued"}, 256'(issued.size()), 256'(e_issued.size()));
        bad = 0;
        for (int i = 0; i < issued.size() && i < e_issued.size(); i++)
            if (issued[i] !== e_issued[i]) bad++;
        chk({tag, ".order"}, 256'(bad), 256'd0);
        chk({tag, ".nlen"}, 256'(lens.size()), 256'(e_count * HASHES));
        bad = 0;
        for (int i = 0; i < lens.size(); i++)
            if (lens[i] !== ((i % HASHES == 1) ? 10'd256 : 10'd640)) bad++;
        chk({tag, ".len"}, 256'(bad), 256'd0);
        chk({tag, ".hold"}, 256'(bad_hold), 256'd0);
        chk({tag, ".overlap"}, 256'(bad_overlap), 256'd0);
        chk({tag, ".idle"}, 256'(busy), 256'd0);
        if (empty) begin
            chk({tag, ".lat_empty"}, 256'(done_cyc - scyc), 256'd2);
        end else begin
            chk({tag, ".lat_start"}, 256'(first_start_cyc - scyc), 256'd1);
            chk({tag, ".lat_done"}, 256'(done_cyc - cdone_cyc), 256'd2);
        end
    endtask

    task automatic search(string tag, logic [HW-1:0] hdr, logic [NW-1:0] ns,
                          logic [NW-1:0] ne, logic [255:0] tgt, int abort_k);
        ref_search(hdr, ns, ne, tgt, abort_k);
        launch(tag, hdr, ns, ne, tgt);
        wait_done(tag, e_count * HASHES * (LAT + 4) + 20);
        verify(tag, ns > ne);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".busy"}, 256'(busy), 256'd0);
        chk({tag, ".done"}, 256'(done), 256'd0);
        chk({tag, ".found"}, 256'(found), 256'd0);
        chk({tag, ".fnonce"}, 256'(found_nonce), 256'd0);
        chk({tag, ".fdigest"}, found_digest, 256'd0);
        chk({tag, ".count"}, 256'(hash_count), 256'd0);
        chk({tag, ".cstart"}, 256'(core_start), 256'd0);
        chk({tag, ".clen"}, 256'(core_len), 256'd0);
        chk({tag, ".cmsg"}, 256'(core_msg != '0), 256'd0);
    endtask

    logic [HW-1:0] hdr;
    logic [255:0]  t2;
    logic [NW-1:0] ns;

    initial begin
        t2 = {224'h0, 32'hFFFF_FFF5};
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        mode = 0;
        search("single", rand_hdr(), 32'd7, 32'd7, 256'd5, 0);

        // digest = ~nonce, so the first hit is nonce 10
        mode = 1;
        hdr = rand_hdr();
        ref_search(hdr, 32'd3, 32'd20, t2, 0);
        launch("walk", hdr, 32'd3, 32'd20, t2);
        wait_starts("walk", 1, 10);
        nonce_start = 32'd0;
        nonce_end = 32'd1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done("walk", 300);
        verify("walk", 0);

        abort = 1'b1;
        search("abort_hit", rand_hdr(), 32'd12, 32'd20, t2, 1);
        abort = 1'b0;

        mode = 2;
        search("top", rand_hdr(), 32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0, 0);
        search("empty", rand_hdr(), 32'd5, 32'd4, {256{1'b1}}, 0);

        hdr = rand_hdr();
        ref_search(hdr, 32'd0, 32'd1000, 256'd0, 3);
        launch("abort", hdr, 32'd0, 32'd1000, 256'd0);
        wait_starts("abort", 3, 100);
        abort = 1'b1;
        wait_done("abort", 100);
        abort = 1'b0;
        verify("abort", 0);

        launch("rst", rand_hdr(), 32'd0, 32'd1000, 256'd0);
        wait_starts("rst", 2, 100);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_zero("rst_async");
        @(negedge clk); #1;
        reset = 1'b0;
        search("after_rst", rand_hdr(), 32'd100, 32'd104, 256'd0, 0);

        for (int r = 0; r < 6; r++) begin
            ns = $urandom;
            ns[31] = 1'b0;
            search("rand", rand_hdr(), ns, ns + NW'($urandom_range(0, 24)),
                   {$urandom_range(0, 32'h2000_0000), {224{1'b1}}}, 0);
        end

`ifdef SHA256_DOUBLE_HASH_EN
        search("double", '0, 32'd0, 32'd0, {256{1'b1}}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
